vec_fetch_decode: RTL and testbench
===================================

Name: vec_fetch_decode

Overview:
- Front end of the vector processor. Fetches 32-bit RVV instructions from instruction memory (synchronous read), decodes them, and buffers them in an issue FIFO.
- The execution stage (load/add/mul/store/dot lanes) consumes decoded packets in program order over a valid/ready handshake.
- Replaces the stage-less fetch/decode-in-one-cycle scheme with a backpressure-aware, resettable stage.

Parameters:
- NUM_INST, 6: instructions in program; fetch stops after index NUM_INST.
- IADDR_W, 3: instruction memory address width; NUM_INST must not exceed 2**IADDR_W.
- FIFO_DEPTH, 4: issue FIFO entries (power of 2, ≥2).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous reset, active high.
- start, input, 1: one-cycle pulse; begins fetch from address 0 when in IDLE.
- imem_rd_en, output, 1: instruction memory read strobe.
- imem_addr, output, IADDR_W: read address, 0-based.
- imem_rdata, input, 32: instruction word, valid the cycle after imem_rd_en.
- iss_valid, output, 1: FIFO head holds a packet.
- iss_ready, input, 1: execution stage accepts the head.
- iss_op, output, 3: 0 LOAD, 1 STORE, 2 ADD, 3 MUL, 4 DOT.
- iss_vd, output, 5: bits[11:7] (vs3 for STORE).
- iss_vs1, output, 5: bits[19:15] (rs1 for LOAD/STORE).
- iss_vs2, output, 5: bits[24:20].
- iss_vm, output, 1: bit[25].
- iss_inum, output, 8: 1-based program index of the packet.
- busy, output, 1: high outside IDLE/DONE.
- done, output, 1: high in DONE.
- illegal_cnt, output, 8: count of dropped instructions, saturating at 255.

Behaviour:
- Reset (async, any state, including mid-fetch):
  - FSM goes to IDLE; FIFO emptied; PC=0; in-flight flag cleared.
  - Outputs: iss_valid=0, imem_rd_en=0, imem_addr=0, busy=0, done=0, illegal_cnt=0.
  - iss_* data fields are 0.
  - A read in flight at reset is discarded.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE→FETCH on start.
  - FETCH→DRAIN the cycle the read of address NUM_INST-1 is issued.
  - DRAIN→DONE when no read is in flight and the FIFO is empty.
  - DONE→FETCH on start (PC reset to 0; illegal_cnt kept).
  - start is ignored in FETCH and DRAIN.
- Fetch rule: in FETCH, imem_rd_en=1 iff (fifo_count + inflight) < FIFO_DEPTH.
  - imem_addr=PC, and PC increments on each issued read.
  - At most one read is in flight.
  - This gives one instruction per cycle sustained when iss_ready=1.
- Decode: combinational on imem_rdata in the cycle after the read; the packet is written to the FIFO on that edge.
  - Latency: start→first iss_valid is 3 cycles (start, read, write; valid in cycle 3).
  - inum = read address + 1.
- Classification:
  - opcode 0000111 with mop[28:26]=000 → LOAD.
  - opcode 0100111 with mop=000 → STORE.
  - opcode 1010111 with funct3=000: funct6 000000 → ADD, 100101 → MUL, 111001 → DOT.
  - Anything else is illegal: not written to the FIFO, illegal_cnt+1 (saturating). The in-flight credit is still released.
- Handshake:
  - The head pops on the edge where iss_valid&&iss_ready.
  - Payload is stable while iss_valid=1 and iss_ready=0.
  - iss_ready while empty has no effect.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push when full cannot occur (guaranteed by the credit rule); assertion required.
  - Packets leave in strict program order.

Test Plan:
- Reset, then start, with the 6-word program 0x0200A087, 0x02012107, 0x021101D7, 0x96118257, 0x020181A7, 0xE61180D7 and iss_ready=1:
  - Six packets with ops 0,0,2,3,1,4 and inum 1..6.
  - Packet 4: vd=4, vs1=3, vs2=1, vm=1.
  - done asserts after the last pop; illegal_cnt=0.
- iss_ready=0 after start: exactly 4 packets buffered and imem_rd_en held low. Raise iss_ready: remaining 2 fetched, all 6 in order, payload stable throughout the stall.
- Replace word 3 with 0x021121D7 (funct3=010): 5 packets (inum 1,2,4,5,6), illegal_cnt=1.
- Assert rst mid-FETCH with 2 entries queued: outputs immediately at reset values. New start refetches from inum 1.
- After DONE, pulse start again: the full 6-packet sequence repeats. start pulsed during FETCH is ignored.
- Random iss_ready (50%), 1000 programs: scoreboard confirms order, no loss or duplication, and the FIFO-full assertion never fires.

Source files
------------

// File: rtl/vec_fetch_decode.sv
// Vector front end: fetches RVV words from synchronous instruction memory, decodes them
// and queues legal packets in an issue FIFO drained over a valid/ready handshake.
module vec_fetch_decode #(
  parameter int NUM_INST   = 6,
  parameter int IADDR_W    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_rd_en,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [2:0]         iss_op,
  output logic [4:0]         iss_vd,
  output logic [4:0]         iss_vs1,
  output logic [4:0]         iss_vs2,
  output logic               iss_vm,
  output logic [7:0]         iss_inum,
  output logic               busy,
  output logic               done,
  output logic [7:0]         illegal_cnt
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic       vm;
    logic [7:0] inum;
  } pkt_t;

  // Returns {legal, op}; anything not recognised comes back with legal=0.
  function automatic logic [3:0] decode_op(input logic [31:0] w);
    logic [3:0] r;
    r = 4'b0000;
    if (w[6:0] == 7'b0000111 && w[28:26] == 3'b000)
      r = {1'b1, 3'd0};
    else if (w[6:0] == 7'b0100111 && w[28:26] == 3'b000)
      r = {1'b1, 3'd1};
    else if (w[6:0] == 7'b1010111 && w[14:12] == 3'b000) begin
      case (w[31:26])
        6'b000000: r = {1'b1, 3'd2};
        6'b100101: r = {1'b1, 3'd3};
        6'b111001: r = {1'b1, 3'd4};
        default:   r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  state_t             state, state_n;
  logic [IADDR_W-1:0] pc;
  logic               vld_p1;
  logic [IADDR_W-1:0] addr_p1;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  pkt_t               fifo_mem [FIFO_DEPTH];
  pkt_t               pkt_p1, head;
  logic [3:0]         dec_p1;
  logic               fetch_ok, last_read, push, pop;

  // Stage p0: issue a read only while a FIFO slot is guaranteed for it.
  assign fetch_ok   = (state == FETCH) &&
                      ((count + CNT_W'(vld_p1)) < CNT_W'(FIFO_DEPTH));
  assign last_read  = fetch_ok && (pc == IADDR_W'(NUM_INST - 1));
  assign imem_rd_en = fetch_ok;
  assign imem_addr  = pc;

  // Stage p1: decode the returned word and push it on the same edge.
  assign dec_p1 = decode_op(imem_rdata);
  always_comb begin
    pkt_p1.op   = dec_p1[2:0];
    pkt_p1.vd   = imem_rdata[11:7];
    pkt_p1.vs1  = imem_rdata[19:15];
    pkt_p1.vs2  = imem_rdata[24:20];
    pkt_p1.vm   = imem_rdata[25];
    pkt_p1.inum = 8'(addr_p1) + 8'd1;
  end

  assign push      = vld_p1 && dec_p1[3];
  assign iss_valid = (count != '0);
  assign pop       = iss_valid && iss_ready;
  assign head      = fifo_mem[rd_ptr];

  // Payload fields read as zero whenever the queue is empty.
  assign iss_op   = iss_valid ? head.op   : '0;
  assign iss_vd   = iss_valid ? head.vd   : '0;
  assign iss_vs1  = iss_valid ? head.vs1  : '0;
  assign iss_vs2  = iss_valid ? head.vs2  : '0;
  assign iss_vm   = iss_valid ? head.vm   : 1'b0;
  assign iss_inum = iss_valid ? head.inum : '0;

  assign busy = (state == FETCH) || (state == DRAIN);
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = FETCH;
      FETCH:   if (last_read) state_n = DRAIN;
      DRAIN:   if (!vld_p1 && count == '0) state_n = DONE;
      DONE:    if (start) state_n = FETCH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      vld_p1      <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      illegal_cnt <= '0;
    end else begin
      state  <= state_n;
      vld_p1 <= fetch_ok;
      if ((state == IDLE || state == DONE) && start) pc <= '0;
      else if (fetch_ok) pc <= pc + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (vld_p1 && !dec_p1[3] && illegal_cnt != 8'hFF)
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_ok) addr_p1 <= pc;
    if (push) fifo_mem[wr_ptr] <= pkt_p1;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && count == CNT_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_vec_fetch_decode.sv
// Directed and randomized-backpressure bench for vec_fetch_decode; expected packets are
// taken from hand-decoded tables or from the fields used to build each instruction word.
module tb_vec_fetch_decode;
  logic        clk = 1'b0;
  logic        rst, start, iss_ready;
  logic        imem_rd_en, iss_valid, iss_vm, busy, done;
  logic [2:0]  imem_addr, iss_op;
  logic [31:0] imem_rdata;
  logic [4:0]  iss_vd, iss_vs1, iss_vs2;
  logic [7:0]  iss_inum, illegal_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [8];
  logic [26:0] popq [$];
  logic [26:0] expq [$];
  int          rd_cnt;
  int          eop [$];
  int          einum [$];

  vec_fetch_decode #(.NUM_INST(6), .IADDR_W(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_vd(iss_vd), .iss_vs1(iss_vs1), .iss_vs2(iss_vs2),
    .iss_vm(iss_vm), .iss_inum(iss_inum),
    .busy(busy), .done(done), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) popq.push_back(pkt_now());
    if (!rst && imem_rd_en) rd_cnt++;
  end

  function automatic logic [26:0] pkt_now();
    return {iss_op, iss_vd, iss_vs1, iss_vs2, iss_vm, iss_inum};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_base();
    mem[0] = 32'h0200A087; mem[1] = 32'h02012107; mem[2] = 32'h021101D7;
    mem[3] = 32'h96118257; mem[4] = 32'h020181A7; mem[5] = 32'hE61180D7;
    mem[6] = 32'h0; mem[7] = 32'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (rnd) iss_ready = 1'($urandom_range(0, 1));
      if (done) begin hit = 1'b1; break; end
    end
    if (!hit) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, popq.size(), eop.size());
    for (int i = 0; i < eop.size() && i < popq.size(); i++) begin
      check({tag, "_op"},   32'(popq[i][26:24]), eop[i]);
      check({tag, "_inum"}, 32'(popq[i][7:0]),   einum[i]);
    end
  endtask

  task automatic set_full_exp();
    eop = '{0, 0, 2, 3, 1, 4};
    einum = '{1, 2, 3, 4, 5, 6};
  endtask

  function automatic logic [31:0] mk(input logic [5:0] hi, input logic vm,
                                     input logic [4:0] vs2, input logic [4:0] vs1,
                                     input logic [2:0] f3, input logic [4:0] vd,
                                     input logic [6:0] opc);
    return {hi, vm, vs2, vs1, f3, vd, opc};
  endfunction

  initial begin
    int unstable, nill, err, k;
    int exp_ill;
    logic [26:0] first;
    logic [2:0]  op;
    logic [4:0]  vd, vs1, vs2;
    logic        vm;
    logic [2:0]  f3;
    logic [5:0]  hi;

    rst = 1'b1; start = 1'b0; iss_ready = 1'b0; imem_rdata = '0;
    load_base();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", iss_valid, 0);
    check("rst_rden", imem_rd_en, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ill", illegal_cnt, 0);
    check("rst_pkt", pkt_now(), 0);
    @(posedge clk); #1; rst = 1'b0;

    // Full program, no backpressure, plus first-valid latency.
    iss_ready = 1'b1; popq.delete(); rd_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy_fetch", busy, 1);
    @(posedge clk); #1;
    check("lat_c2", iss_valid, 0);
    @(posedge clk); #1;
    check("lat_c3", iss_valid, 1);
    run_until_done(100, 1'b0);
    set_full_exp();
    check_seq("base");
    if (popq.size() >= 4)
      check("pkt4", popq[3], {3'd3, 5'd4, 5'd3, 5'd1, 1'b1, 8'd4});
    check("base_ill", illegal_cnt, 0);
    check("base_done", done, 1);
    check("base_busy", busy, 0);

    // Stall: ready low fills exactly four slots and stops fetching.
    iss_ready = 1'b0; popq.delete(); rd_cnt = 0; unstable = 0;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    first = pkt_now();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (pkt_now() !== first || !iss_valid) unstable++;
    end
    check("stall_reads", rd_cnt, 4);
    check("stall_rden", imem_rd_en, 0);
    check("stall_head", first, {3'd0, 5'd1, 5'd1, 5'd0, 1'b1, 8'd1});
    check("stall_stable", unstable, 0);
    iss_ready = 1'b1;
    run_until_done(100, 1'b0);
    set_full_exp();
    check_seq("stall");
    check("stall_reads_total", rd_cnt, 6);

    // Illegal word 3 (funct3=010) is dropped and counted.
    mem[2] = 32'h021121D7; popq.delete();
    pulse_start();
    run_until_done(100, 1'b0);
    eop = '{0, 0, 3, 1, 4};
    einum = '{1, 2, 4, 5, 6};
    check_seq("ill");
    check("ill_cnt", illegal_cnt, 1);

    // Asynchronous reset with two packets queued mid-fetch.
    load_base(); iss_ready = 1'b0; popq.delete();
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1; #1;
    check("arst_valid", iss_valid, 0);
    check("arst_rden", imem_rd_en, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_busy", busy, 0);
    check("arst_ill", illegal_cnt, 0);
    check("arst_pkt", pkt_now(), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    iss_ready = 1'b1; popq.delete();
    pulse_start();
    run_until_done(100, 1'b0);
    set_full_exp();
    check_seq("post_rst");

    // Restart from DONE, with a stray start during FETCH.
    popq.delete(); rd_cnt = 0;
    pulse_start();
    @(posedge clk); #1;
    pulse_start();
    run_until_done(100, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    set_full_exp();
    check_seq("restart");
    check("restart_reads", rd_cnt, 6);
    check("restart_done", done, 1);

    // Random programs under 50% backpressure; illegal count must saturate.
    exp_ill = 0;
    for (int p = 0; p < 1000; p++) begin
      expq.delete(); popq.delete(); nill = 0;
      for (int i = 0; i < 6; i++) begin
        vd = 5'($urandom); vs1 = 5'($urandom); vs2 = 5'($urandom); vm = 1'($urandom);
        if ($urandom_range(0, 5) == 0) begin
          k = $urandom_range(0, 3);
          case (k)
            0: mem[i] = mk(6'b000000, vm, vs2, vs1, 3'($urandom_range(1, 7)), vd, 7'b1010111);
            1: mem[i] = mk(6'b000001, vm, vs2, vs1, 3'b000, vd, 7'b1010111);
            2: mem[i] = mk({3'b000, 3'($urandom_range(1, 7))}, vm, vs2, vs1, 3'b000, vd, 7'b0000111);
            default: mem[i] = mk(6'b000000, vm, vs2, vs1, 3'b000, vd, 7'b0110011);
          endcase
          nill++;
        end else begin
          op = 3'($urandom_range(0, 4));
          f3 = 3'($urandom);
          hi = {3'($urandom), 3'b000};
          case (op)
            3'd0: mem[i] = mk(hi, vm, vs2, vs1, f3, vd, 7'b0000111);
            3'd1: mem[i] = mk(hi, vm, vs2, vs1, f3, vd, 7'b0100111);
            3'd2: mem[i] = mk(6'b000000, vm, vs2, vs1, 3'b000, vd, 7'b1010111);
            3'd3: mem[i] = mk(6'b100101, vm, vs2, vs1, 3'b000, vd, 7'b1010111);
            default: mem[i] = mk(6'b111001, vm, vs2, vs1, 3'b000, vd, 7'b1010111);
          endcase
          expq.push_back({op, vd, vs1, vs2, vm, 8'(i + 1)});
        end
      end
      pulse_start();
      run_until_done(300, 1'b1);
      err = 0;
      for (int i = 0; i < expq.size() && i < popq.size(); i++)
        if (popq[i] !== expq[i]) err++;
      exp_ill = (exp_ill + nill > 255) ? 255 : exp_ill + nill;
      check("rnd_len", popq.size(), expq.size());
      check("rnd_err", err, 0);
      check("rnd_ill", illegal_cnt, exp_ill);
    end
    check("ill_saturated", illegal_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
